// File: rtl/aes_dec_pkg.sv
// Shared AES decryption definitions: state geometry, byte slicing and the
// InvSubBytes sequencer state encoding.
package aes_dec_pkg;

  localparam int AES_BYTES   = 16;
  localparam int AES_STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } decState_e;

  // Byte 0 is the most significant byte of the state word.
  function automatic logic [7:0] get_byte(input logic [AES_STATE_W-1:0] state,
                                          input logic [3:0]             b);
    return state[(AES_BYTES-1-int'(b))*8 +: 8];
  endfunction

endpackage

// File: rtl/inv_sub_box.sv
// AES inverse S-box lookup with a LAT-deep output register pipeline.
// No reset: the sequencer ignores any result that was not tagged valid.
module inv_sub_box #(
  parameter int LAT = 1
) (
  input  logic       i_clk,
  input  logic [7:0] i_addr,
  output logic [7:0] o_data
);

  // Entry a sits at bits [(255-a)*8 +: 8], one table row per 128-bit word.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [7:0] r_pipe [LAT];

  always_ff @(posedge i_clk) begin
    r_pipe[0] <= INV_SBOX[(255-int'(i_addr))*8 +: 8];
    for (int i = 1; i < LAT; i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[LAT-1];

endmodule

// File: rtl/inv_subbytes_seq.sv
// InvSubBytes over a 128-bit AES state, time-multiplexed onto LANES shared
// inverse S-box instances with a ready/valid handshake on both sides.
module inv_subbytes_seq
  import aes_dec_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int SBOX_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  localparam int N     = AES_BYTES / LANES;
  localparam int CNT_W = $clog2(N) + 1;

  decState_e              r_state;
  decState_e              w_stateNext;
  logic [CNT_W-1:0]       r_cnt;
  logic [AES_STATE_W-1:0] r_src;
  logic [AES_STATE_W-1:0] r_res;
  logic                   r_tagVld [SBOX_LAT];
  logic [CNT_W-1:0]       r_tagGrp [SBOX_LAT];
  logic [7:0]             w_addr    [LANES];
  logic [7:0]             w_sboxOut [LANES];
  logic                   w_push;
  logic                   w_retire;
  logic                   w_lastRetire;

  // Lane l of group cnt handles byte cnt*LANES+l; cnt may sit past the end
  // while draining, where the truncated address is harmless.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_addr[l] = get_byte(r_src, 4'(int'(r_cnt) * LANES + l));

    inv_sub_box #(
      .LAT (SBOX_LAT)
    ) u_box (
      .i_clk  (clk),
      .i_addr (w_addr[l]),
      .o_data (w_sboxOut[l])
    );
  end

  assign w_retire     = r_tagVld[SBOX_LAT-1];
  assign w_lastRetire = w_retire && (r_tagGrp[SBOX_LAT-1] == CNT_W'(N-1));

  always_comb begin
    w_stateNext = r_state;
    w_push      = 1'b0;
    case (r_state)
      IDLE:    if (in_valid) w_stateNext = ISSUE;
      ISSUE: begin
        w_push = 1'b1;
        if (r_cnt == CNT_W'(N-1)) w_stateNext = DRAIN;
      end
      DRAIN:   if (w_lastRetire) w_stateNext = DONE;
      DONE:    if (out_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_src   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == IDLE && in_valid) begin
        r_src <= in_state;
        r_cnt <= '0;
      end else if (r_state == ISSUE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Tags travel alongside the lookups so only tagged results land in res_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res <= '0;
      for (int i = 0; i < SBOX_LAT; i++) begin
        r_tagVld[i] <= 1'b0;
        r_tagGrp[i] <= '0;
      end
    end else begin
      r_tagVld[0] <= w_push;
      r_tagGrp[0] <= r_cnt;
      for (int i = 1; i < SBOX_LAT; i++) begin
        r_tagVld[i] <= r_tagVld[i-1];
        r_tagGrp[i] <= r_tagGrp[i-1];
      end
      for (int b = 0; b < AES_BYTES; b++) begin
        if (w_retire && r_tagGrp[SBOX_LAT-1] == CNT_W'(b / LANES)) begin
          r_res[(AES_BYTES-1-b)*8 +: 8] <= w_sboxOut[b % LANES];
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == ISSUE) || (r_state == DRAIN);
  assign out_state = r_res;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Directed bench for inv_subbytes_seq: main instance at LANES=4 plus LANES=1
// and LANES=16 instances for latency, all against hand-computed vectors.
module tb_inv_subbytes_seq;

  localparam logic [127:0] VEC_FWD  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] VEC_IDX  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_ROW0 = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] VEC_52   = {16{8'h52}};
  localparam logic [127:0] VEC_FF   = {16{8'hff}};
  localparam logic [127:0] VEC_7D   = {16{8'h7d}};

  logic         clk;
  logic         rstN;
  logic [127:0] inState;

  logic         inValid, inReady, outValid, outReady, busy;
  logic [127:0] outState;
  logic         inValid1, inReady1, outValid1, busy1;
  logic [127:0] outState1;
  logic         inValid16, inReady16, outValid16, busy16;
  logic [127:0] outState16;

  int checks;
  int failures;

  inv_subbytes_seq #(.LANES(4), .SBOX_LAT(1)) u_dut (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
    .in_state(inState), .out_valid(outValid), .out_ready(outReady),
    .out_state(outState), .busy(busy)
  );

  inv_subbytes_seq #(.LANES(1), .SBOX_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid1), .in_ready(inReady1),
    .in_state(inState), .out_valid(outValid1), .out_ready(1'b1),
    .out_state(outState1), .busy(busy1)
  );

  inv_subbytes_seq #(.LANES(16), .SBOX_LAT(1)) u_dut16 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid16), .in_ready(inReady16),
    .in_state(inState), .out_valid(outValid16), .out_ready(1'b1),
    .out_state(outState16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h", tag, observed, expected);
    end
  endtask

  // Present one state to the main instance; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [127:0] state);
    int waited;
    waited = 0;
    while (!inReady && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_before_accept", 128'(inReady), 128'(1));
    inValid = 1'b1;
    inState = state;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic waitOutput(output int lat);
    lat = 0;
    while (!outValid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finishOutput();
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  int lat, lat1, lat16, latM, badCycles, hsCount;
  logic [127:0] res1, res16, resM;
  logic [127:0] expQ [3];
  logic [127:0] gotQ [$];
  int           hsTime [$];
  int           cyc;

  initial begin
    checks = 0; failures = 0;
    rstN = 1'b0; inValid = 1'b0; inValid1 = 1'b0; inValid16 = 1'b0;
    outReady = 1'b0; inState = '0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("reset_out_valid", 128'(outValid), 128'(0));
    checkOutput("reset_out_state", outState, 128'h0);
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_in_ready", 128'(inReady), 128'(1));

    // T1 all-zero state
    applyStimulus(128'h0);
    waitOutput(lat);
    checkOutput("t1_latency", 128'(lat), 128'(5));
    checkOutput("t1_state", outState, VEC_52);
    finishOutput();

    // T2 known vector
    applyStimulus(VEC_FWD);
    waitOutput(lat);
    checkOutput("t2_latency", 128'(lat), 128'(5));
    checkOutput("t2_state", outState, VEC_IDX);
    finishOutput();

    // T3 latency across lane counts, all accepted on the same edge
    inValid = 1'b1; inValid1 = 1'b1; inValid16 = 1'b1; inState = VEC_FWD;
    @(negedge clk);
    inValid = 1'b0; inValid1 = 1'b0; inValid16 = 1'b0; inState = ~VEC_FWD;
    lat1 = -1; lat16 = -1; latM = -1;
    res1 = '0; res16 = '0; resM = '0;
    for (int j = 0; j < 30; j++) begin
      if (lat1 < 0 && outValid1) begin lat1 = j; res1 = outState1; end
      if (lat16 < 0 && outValid16) begin lat16 = j; res16 = outState16; end
      if (latM < 0 && outValid) begin latM = j; resM = outState; end
      @(negedge clk);
    end
    checkOutput("t3_lat_lanes4", 128'(latM), 128'(5));
    checkOutput("t3_lat_lanes1", 128'(lat1), 128'(17));
    checkOutput("t3_lat_lanes16", 128'(lat16), 128'(2));
    checkOutput("t3_state_lanes4", resM, VEC_IDX);
    checkOutput("t3_state_lanes1", res1, VEC_IDX);
    checkOutput("t3_state_lanes16", res16, VEC_IDX);
    finishOutput();

    // T4 backpressure with a competing in_valid
    applyStimulus(VEC_IDX);
    waitOutput(lat);
    checkOutput("t4_latency", 128'(lat), 128'(5));
    badCycles = 0;
    inValid = 1'b1; inState = VEC_FF;
    for (int j = 0; j < 10; j++) begin
      if (!outValid || outState !== VEC_ROW0 || inReady || busy) badCycles++;
      @(negedge clk);
    end
    checkOutput("t4_hold_bad_cycles", 128'(badCycles), 128'(0));
    checkOutput("t4_state_held", outState, VEC_ROW0);
    inValid = 1'b0;
    finishOutput();
    checkOutput("t4_in_ready_after", 128'(inReady), 128'(1));
    checkOutput("t4_out_valid_after", 128'(outValid), 128'(0));
    checkOutput("t4_second_ignored", 128'(busy), 128'(0));

    // T5 reset during ISSUE with cnt=2
    applyStimulus(VEC_FWD);
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("t5_out_valid", 128'(outValid), 128'(0));
    checkOutput("t5_out_state", outState, 128'h0);
    checkOutput("t5_busy", 128'(busy), 128'(0));
    badCycles = 0;
    for (int j = 0; j < 8; j++) begin
      if (outValid || busy || outState !== 128'h0) badCycles++;
      @(negedge clk);
    end
    checkOutput("t5_quiet_after_reset", 128'(badCycles), 128'(0));
    applyStimulus(VEC_FF);
    waitOutput(lat);
    checkOutput("t5_latency", 128'(lat), 128'(5));
    checkOutput("t5_state", outState, VEC_7D);
    finishOutput();

    // T6 back-to-back with in_state scrambled right after each accept
    expQ[0] = VEC_IDX; expQ[1] = VEC_ROW0; expQ[2] = VEC_52;
    outReady = 1'b1;
    cyc = 0;
    fork
      begin
        logic [127:0] vecs [3];
        vecs[0] = VEC_FWD; vecs[1] = VEC_IDX; vecs[2] = 128'h0;
        for (int k = 0; k < 3; k++) begin
          applyStimulus(vecs[k]);
          inState = ~vecs[k];
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          if (outValid && outReady) begin
            gotQ.push_back(outState);
            hsTime.push_back(cyc);
          end
          @(negedge clk);
          cyc++;
        end
      end
    join
    outReady = 1'b0;
    hsCount = gotQ.size();
    checkOutput("t6_handshakes", 128'(hsCount), 128'(3));
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("t6_state_%0d", k),
                  (k < hsCount) ? gotQ[k] : 128'hx, expQ[k]);
    end
    if (hsCount >= 3) begin
      checkOutput("t6_spacing_0", 128'(hsTime[1] - hsTime[0]), 128'(7));
      checkOutput("t6_spacing_1", 128'(hsTime[2] - hsTime[1]), 128'(7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
